fp_add_align_stage: RTL and testbench
=====================================

Name: fp_add_align_stage

Overview:
- First stage of the single-precision FP adder datapath.
- Takes two raw IEEE-754 binary32 operands and splits each into sign, exponent and fraction (mask function).
- Aligns the two significands so both refer to the larger exponent (alignment function).
- Output is one registered pipeline stage that feeds the add/normalise stage.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Operand width is 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid this cycle
- a  in  32  operand A, binary32
- b  in  32  operand B, binary32
- out_valid  out  1  registered outputs valid
- sign_a, sign_b  out  1 each  operand sign bits (bit 31)
- exp_a, exp_b  out  8 each  operand exponent fields (bits 30:23)
- man_a, man_b  out  23 each  operand fraction fields (bits 22:0)
- exp_out  out  8  common exponent for normalisation: max(exp_a, exp_b)
- aligned_man_a, aligned_man_b  out  24 each  aligned significands with hidden bit
- a_exp_ge  out  1  1 when exp_a >= exp_b

Behaviour:
- Mask (combinational):
  - sign = bit 31, exp = bits 30:23, man = bits 22:0, for each operand.
- Significand extension:
  - sig = {1'b1, man}.
  - The hidden bit is always 1; zero, denormal, Inf and NaN get no special handling here (handled downstream).
- Alignment (combinational), compare exponents unsigned:
  - exp_a > exp_b: exp_out = exp_a; aligned_man_a = sig_a; aligned_man_b = sig_b >> (exp_a - exp_b).
  - exp_b > exp_a: exp_out = exp_b; aligned_man_b = sig_b; aligned_man_a = sig_a >> (exp_b - exp_a).
  - Equal exponents: exp_out = exp_a; both significands unshifted; a_exp_ge = 1.
- Shift rules:
  - Logical right shift; 8-bit unsigned difference, always non-negative, no wrap.
  - diff >= 24 yields 0. diff = 23 yields 0x000001.
  - Shifted-out bits are discarded: no guard/round/sticky at this stage.
- Selection is by exponent field only, never by full 32-bit magnitude or sign.
- Pipeline:
  - All outputs are registered; latency exactly 1 cycle.
  - On each rising clk, outputs load the values computed from the current a/b.
  - out_valid <= in_valid.
  - Data registers load every cycle regardless of in_valid; consumers qualify with out_valid.
  - Full throughput: one pair per cycle, no backpressure, no stall.
- Reset:
  - rst_n low immediately clears every output (including out_valid) to 0, independent of clk.
  - Reset mid-stream drops the in-flight pair.
  - First valid output appears one clock after in_valid is sampled with rst_n high.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MAN_W, SIG_W (= MAN_W+1).
  - typedef fp32_t packed struct {sign, exp, man}.
  - typedef sig_t [SIG_W-1:0].
- One natural combinational sub-module: fp_mantissa_aligner.
  - Inputs: exponents and fractions.
  - Outputs: exp_out, aligned significands, a_exp_ge.
- The mask is a struct cast in the top module, not a separate module.

Test Plan:
- A=0x40000000, B=0x3F800000 -> after 1 clk: exp_out=128, aligned_man_a=0x800000, aligned_man_b=0x400000, a_exp_ge=1.
- A=0x3F800000, B=0x41000000 -> exp_out=130, aligned_man_a=0x100000, aligned_man_b=0x800000, a_exp_ge=0.
- A=0x3FC00000, B=0xBF800000 (equal exp) -> exp_out=127, aligned_man_a=0xC00000, aligned_man_b=0x800000, sign_b=1, man_a=0x400000.
- A=0x7F000000, B=0x3F800000 (diff 127) -> aligned_man_b=0. Second pair with diff 23 -> aligned_man_b=0x000001. Diff 24 -> 0.
- Drive a valid pair, then pull rst_n low mid-cycle -> all outputs 0 without a clk edge. Release -> out_valid stays 0 until the next sampled in_valid.
- 2048 back-to-back random pairs with in_valid toggling -> each cycle's outputs match a reference model of the previous cycle's inputs; out_valid tracks in_valid delayed by 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the single-precision FP adder datapath.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef logic [SIG_W-1:0] sig_t;

    typedef struct packed {
        logic             valid;
        fp32_t            a;
        fp32_t            b;
        logic [EXP_W-1:0] exp_out;
        sig_t             aligned_a;
        sig_t             aligned_b;
        logic             a_exp_ge;
    } align_stage_t;

    // Logical right shift that flushes to zero once every significand bit is gone.
    function automatic sig_t shift_sig(input sig_t sig, input logic [EXP_W-1:0] diff);
        sig_t res;
        res = '0;
        if (diff < EXP_W'(SIG_W)) begin
            res = sig >> diff;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_mantissa_aligner.sv
// Aligns two significands to the larger exponent; selection uses exponent fields only.
module fp_mantissa_aligner
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] exp_a_i,
    input  logic [EXP_W-1:0] exp_b_i,
    input  logic [MAN_W-1:0] man_a_i,
    input  logic [MAN_W-1:0] man_b_i,
    output logic [EXP_W-1:0] exp_out_c,
    output sig_t             aligned_a_c,
    output sig_t             aligned_b_c,
    output logic             a_exp_ge_c
);

    sig_t             sig_a;
    sig_t             sig_b;
    logic [EXP_W-1:0] diff_ab;
    logic [EXP_W-1:0] diff_ba;

    // Hidden bit is forced to 1; special operands are resolved downstream.
    assign sig_a   = {1'b1, man_a_i};
    assign sig_b   = {1'b1, man_b_i};
    assign diff_ab = exp_a_i - exp_b_i;
    assign diff_ba = exp_b_i - exp_a_i;

    always_comb begin
        exp_out_c   = exp_a_i;
        aligned_a_c = sig_a;
        aligned_b_c = sig_b;
        a_exp_ge_c  = 1'b1;
        if (exp_a_i >= exp_b_i) begin
            aligned_b_c = shift_sig(sig_b, diff_ab);
        end else begin
            exp_out_c   = exp_b_i;
            aligned_a_c = shift_sig(sig_a, diff_ba);
            a_exp_ge_c  = 1'b0;
        end
    end

endmodule

// File: rtl/fp_add_align_stage.sv
// First FP adder stage: field split, significand alignment, one register stage.
module fp_add_align_stage
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FP_W-1:0]   a,
    input  logic [FP_W-1:0]   b,
    output logic              out_valid,
    output logic              sign_a,
    output logic              sign_b,
    output logic [EXP_W-1:0]  exp_a,
    output logic [EXP_W-1:0]  exp_b,
    output logic [MAN_W-1:0]  man_a,
    output logic [MAN_W-1:0]  man_b,
    output logic [EXP_W-1:0]  exp_out,
    output logic [SIG_W-1:0]  aligned_man_a,
    output logic [SIG_W-1:0]  aligned_man_b,
    output logic              a_exp_ge
);

    fp32_t            op_a;
    fp32_t            op_b;
    logic [EXP_W-1:0] exp_out_c;
    sig_t             aligned_a_c;
    sig_t             aligned_b_c;
    logic             a_exp_ge_c;
    align_stage_t     stage_d;
    align_stage_t     stage_q;

    assign op_a = fp32_t'(a);
    assign op_b = fp32_t'(b);

    fp_mantissa_aligner u_aligner (
        .exp_a_i     (op_a.exp),
        .exp_b_i     (op_b.exp),
        .man_a_i     (op_a.man),
        .man_b_i     (op_b.man),
        .exp_out_c   (exp_out_c),
        .aligned_a_c (aligned_a_c),
        .aligned_b_c (aligned_b_c),
        .a_exp_ge_c  (a_exp_ge_c)
    );

    // Data loads every cycle; consumers qualify with valid.
    always_comb begin
        stage_d           = '0;
        stage_d.valid     = in_valid;
        stage_d.a         = op_a;
        stage_d.b         = op_b;
        stage_d.exp_out   = exp_out_c;
        stage_d.aligned_a = aligned_a_c;
        stage_d.aligned_b = aligned_b_c;
        stage_d.a_exp_ge  = a_exp_ge_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid     = stage_q.valid;
    assign sign_a        = stage_q.a.sign;
    assign sign_b        = stage_q.b.sign;
    assign exp_a         = stage_q.a.exp;
    assign exp_b         = stage_q.b.exp;
    assign man_a         = stage_q.a.man;
    assign man_b         = stage_q.b.man;
    assign exp_out       = stage_q.exp_out;
    assign aligned_man_a = stage_q.aligned_a;
    assign aligned_man_b = stage_q.aligned_b;
    assign a_exp_ge      = stage_q.a_exp_ge;

endmodule

// File: tb/tb_fp_add_align_stage.sv
// Self-checking bench for fp_add_align_stage: directed table, reset sequence, random vs model.
module tb_fp_add_align_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [22:0] man_a;
    logic [22:0] man_b;
    logic [7:0]  exp_out;
    logic [23:0] aligned_man_a;
    logic [23:0] aligned_man_b;
    logic        a_exp_ge;

    int n_cmp;
    int n_err;

    fp_add_align_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .sign_a        (sign_a),
        .sign_b        (sign_b),
        .exp_a         (exp_a),
        .exp_b         (exp_b),
        .man_a         (man_a),
        .man_b         (man_b),
        .exp_out       (exp_out),
        .aligned_man_a (aligned_man_a),
        .aligned_man_b (aligned_man_b),
        .a_exp_ge      (a_exp_ge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          eo;
        int          am;
        int          bm;
        int          ge;
    } vec_t;

    typedef struct {
        int sa, sb, ea, eb, ma, mb, eo, am, bm, ge;
    } model_t;

    // Reference: value-level description of the alignment rules.
    function automatic model_t model(input logic [31:0] x, input logic [31:0] y);
        model_t m;
        int     sig_x;
        int     sig_y;
        int     d;
        m.sa  = int'(x[31]);
        m.sb  = int'(y[31]);
        m.ea  = int'(x[30:23]);
        m.eb  = int'(y[30:23]);
        m.ma  = int'(x[22:0]);
        m.mb  = int'(y[22:0]);
        sig_x = 8388608 + m.ma;
        sig_y = 8388608 + m.mb;
        if (m.ea >= m.eb) begin
            d    = m.ea - m.eb;
            m.eo = m.ea;
            m.am = sig_x;
            m.bm = (d > 23) ? 0 : sig_y / (1 << d);
            m.ge = 1;
        end else begin
            d    = m.eb - m.ea;
            m.eo = m.eb;
            m.bm = sig_y;
            m.am = (d > 23) ? 0 : sig_x / (1 << d);
            m.ge = 0;
        end
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_signs"}, int'({sign_a, sign_b}), 0);
        check({tag, "_exps"},  int'({exp_a, exp_b}), 0);
        check({tag, "_man_a"}, int'(man_a), 0);
        check({tag, "_man_b"}, int'(man_b), 0);
        check({tag, "_exp_out"}, int'(exp_out), 0);
        check({tag, "_am"}, int'(aligned_man_a), 0);
        check({tag, "_bm"}, int'(aligned_man_b), 0);
        check({tag, "_ge"}, int'(a_exp_ge), 0);
    endtask

    task automatic check_model(input string tag, input model_t m, input logic v);
        check({tag, "_valid"},   int'(out_valid), int'(v));
        check({tag, "_sign_a"},  int'(sign_a), m.sa);
        check({tag, "_sign_b"},  int'(sign_b), m.sb);
        check({tag, "_exp_a"},   int'(exp_a), m.ea);
        check({tag, "_exp_b"},   int'(exp_b), m.eb);
        check({tag, "_man_a"},   int'(man_a), m.ma);
        check({tag, "_man_b"},   int'(man_b), m.mb);
        check({tag, "_exp_out"}, int'(exp_out), m.eo);
        check({tag, "_am"},      int'(aligned_man_a), m.am);
        check({tag, "_bm"},      int'(aligned_man_b), m.bm);
        check({tag, "_ge"},      int'(a_exp_ge), m.ge);
    endtask

    vec_t   vecs[$];
    model_t mref;
    logic   v_rand;
    int     ex;
    int     ey;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;

        vecs.push_back('{32'h40000000, 32'h3F800000, 128, 32'h800000, 32'h400000, 1});
        vecs.push_back('{32'h3F800000, 32'h41000000, 130, 32'h100000, 32'h800000, 0});
        vecs.push_back('{32'h3FC00000, 32'hBF800000, 127, 32'hC00000, 32'h800000, 1});
        vecs.push_back('{32'h7F000000, 32'h3F800000, 254, 32'h800000, 32'h000000, 1});
        vecs.push_back('{32'h4B000000, 32'h3F800000, 150, 32'h800000, 32'h000001, 1});
        vecs.push_back('{32'h4B800000, 32'h3F800000, 151, 32'h800000, 32'h000000, 1});
        vecs.push_back('{32'h3FFFFFFF, 32'h4B000000, 150, 32'h000001, 32'h800000, 0});
        vecs.push_back('{32'hC0000000, 32'h3F800000, 128, 32'h800000, 32'h400000, 1});
        vecs.push_back('{32'h00000000, 32'h00000000,   0, 32'h800000, 32'h800000, 1});
        vecs.push_back('{32'h3F800000, 32'h3F800001, 127, 32'h800000, 32'h800001, 1});

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed vectors with hand-derived expectations.
        foreach (vecs[i]) begin
            @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i),   int'(out_valid), 1);
            check($sformatf("vec%0d_exp_out", i), int'(exp_out), vecs[i].eo);
            check($sformatf("vec%0d_am", i),      int'(aligned_man_a), vecs[i].am);
            check($sformatf("vec%0d_bm", i),      int'(aligned_man_b), vecs[i].bm);
            check($sformatf("vec%0d_ge", i),      int'(a_exp_ge), vecs[i].ge);
        end
        check("vec2_sign_b", int'(sign_b), 0);
        @(negedge clk);
        a = 32'h3FC00000;
        b = 32'hBF800000;
        @(posedge clk);
        #1;
        check("eq_sign_b", int'(sign_b), 1);
        check("eq_man_a",  int'(man_a), 32'h400000);
        check("eq_exp_b",  int'(exp_b), 127);

        // Asynchronous reset mid-cycle, then recovery.
        @(negedge clk);
        a        = 32'h40000000;
        b        = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", int'(out_valid), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid0", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("post_rst_valid1", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_first_valid", int'(out_valid), 1);
        check("post_rst_exp_out", int'(exp_out), 128);

        // Random back-to-back stream, exponents often close to exercise shift boundaries.
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                ex = int'(a[30:23]);
                ey = ex + int'($urandom_range(0, 60)) - 30;
                if (ey < 0) ey = 0;
                if (ey > 255) ey = 255;
                b[30:23] = 8'(ey);
            end
            v_rand   = 1'($urandom_range(0, 1));
            in_valid = v_rand;
            mref     = model(a, b);
            @(posedge clk);
            #1;
            check_model("rand", mref, v_rand);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
